cpu_run_ctrl: RTL

Run/step/breakpoint controller for the pipelined CPU on the FPGA demo board. It sits between the board inputs (step push-button, run switch, breakpoint switches) and the CPU, and produces a single clock-enable that the CPU uses to advance. It debounces the step button, sequences single-step, free-run and breakpoint-halt modes, and counts executed cycles for display on the seven-segment driver.

---
 rtl/cpu_run_ctrl.sv | 93 +++++++++
 1 files changed

// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint controller: debounces the step button, sequences
// IDLE/STEP/RUN/BREAK and produces the CPU clock-enable plus an executed-cycle count.
module cpu_run_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_btn,
  input  logic             run_sw,
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
  input  logic [31:0]      pc,
  output logic             cpu_en,
  output logic             halted,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] STEP  = 2'b01;
  localparam logic [1:0] RUN   = 2'b10;
  localparam logic [1:0] BREAK = 2'b11;

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;

  logic            sync1, sync2;
  logic            db, db_d;
  logic [DB_W-1:0] db_cnt;
  logic            step_pulse;
  logic            bp_hit;
  logic [1:0]      state_next;

  // Two-flop synchronizer feeding a counter-based debouncer.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      db     <= 1'b0;
      db_d   <= 1'b0;
      db_cnt <= '0;
      step_pulse <= 1'b0;
    end else begin
      sync1 <= step_btn;
      sync2 <= sync1;
      db_d  <= db;
      step_pulse <= db & ~db_d;
      if (sync2 == db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        db     <= sync2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  assign bp_hit = bp_en && (pc == bp_addr);

  // Dropping run_sw always wins, so a breakpoint or step pulse arriving with it is discarded.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (run_sw) state_next = RUN;
               else if (step_pulse) state_next = STEP;
      STEP:    state_next = IDLE;
      RUN:     if (!run_sw) state_next = IDLE;
               else if (bp_hit) state_next = BREAK;
      BREAK:   if (!run_sw) state_next = IDLE;
               else if (step_pulse) state_next = STEP;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Enable drops combinationally so the CPU never advances past bp_addr or a dropped switch.
  assign cpu_en = (state == STEP) || (state == RUN && run_sw && !bp_hit);
  assign halted = (state == IDLE) || (state == BREAK);

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= '0;
    end else if (cpu_en && (cycle_cnt != {CNT_W{1'b1}})) begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end

endmodule
